reset_req_ctrl: RTL
===================

Name: reset_req_ctrl

Overview:
- Reset-request controller directly upstream of the system reset generator. Its reset_req output drives the generator's reset_in.
- Merges three reset sources into one clean, minimum-width, active-high request: PLL lock status (asynchronous), host soft reset (4-phase handshake) and an internal watchdog.
- Records which source caused the last reset in a sticky cause register readable by the host CSR block.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for pll_locked_async (legal values 2..4)
- LOCK_FILTER, 64, consecutive cycles the synchronised lock must be high before release (1..65535)
- MIN_PULSE, 16, minimum reset_req assertion length in cycles (1..65535)
- WDT_TIMEOUT, 24'd10000000, watchdog expiry in cycles without a kick (2..2^24-1)

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous active-low reset; assertion is async, deassertion is synchronous to clk (board-level synchroniser)
- pll_locked_async  in  1  PLL lock, asynchronous to clk
- soft_req  in  1  host soft-reset request, level, synchronous to clk
- soft_ack  out  1  soft-reset completion acknowledge
- wdt_enable  in  1  watchdog enable, synchronous
- wdt_kick  in  1  single-cycle watchdog restart
- cause_clr  in  1  single-cycle clear of the cause register
- reset_req  out  1  active-high reset request to the reset generator
- cause  out  4  sticky cause: [0] power-on/reset_n, [1] lock loss, [2] soft, [3] watchdog

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, reset_n).
- Values while reset_n = 0:
  - reset_req = 1, soft_ack = 0, cause = 4'b0001
  - state = ASSERT; all counters 0; synchroniser flops 0
- lock_s is pll_locked_async after SYNC_STAGES flops. Latency from pin to lock_s is SYNC_STAGES cycles.
- Lock filter counter:
  - Clears in any cycle with lock_s = 0.
  - Otherwise increments, saturating at LOCK_FILTER.
  - lock_ok = (filter == LOCK_FILTER).
- State ASSERT:
  - reset_req = 1; pulse counter increments, saturating at MIN_PULSE; watchdog counter held at 0.
  - Moves to RUN when pulse counter == MIN_PULSE and lock_ok.
  - A lock drop during ASSERT restarts the filter only, not the pulse counter.
- State RUN:
  - reset_req = 0, registered. The first RUN cycle is the first cycle with reset_req = 0.
  - Exit events, checked in the same cycle:
    - L: lock_s = 0
    - W: wdt_enable and wdt count == WDT_TIMEOUT-1 and no wdt_kick
    - S: soft_req = 1 and soft_ack = 0 and no soft request pending
  - Any of L/W/S moves the FSM to ASSERT on the next edge, clears the pulse counter and sets soft_pend if S.
  - Every cause bit whose event is true in that cycle is set, so simultaneous events set multiple bits.
- Watchdog:
  - In RUN, wdt_kick or !wdt_enable clears the count; otherwise it increments.
  - The count never wraps.
- Soft-reset handshake (4-phase):
  - Host raises soft_req and holds it high.
  - The block asserts reset_req for the full ASSERT period.
  - On the cycle after returning to RUN with soft_pend set, soft_ack rises and soft_pend clears.
  - soft_ack falls the cycle after soft_req is seen low.
  - While soft_ack = 1, soft_req does not retrigger.
  - If soft_req drops before the ack, the reset still completes and soft_ack pulses for one cycle.
- Cause register:
  - Only reset_n sets bit 0.
  - cause_clr zeroes all bits; an event setting a bit in the same cycle wins.
  - Bits set again while already set stay set.
- Reset_n asserted mid-operation: state is forced to the values listed for reset_n = 0 immediately, without waiting for a clock edge. Any pending handshake is abandoned and soft_ack = 0.
- Minimum latencies from event to reset_req = 1:
  - soft/watchdog: 1 cycle
  - lock loss: SYNC_STAGES+1 cycles
- Counter widths: $clog2(param+1). No arithmetic overflow is possible with legal parameters.

Decomposition:
- Shared package rst_pkg: state enum {ASSERT, RUN}, cause bit index constants (CAUSE_POR=0, CAUSE_LOCK=1, CAUSE_SOFT=2, CAUSE_WDT=3), cause width constant.
- Sub-module bit_sync (STAGES parameter, async active-low reset to 0) for the lock synchroniser. The codebase reuses it for other CDC single bits.

Test Plan:
- Power-on, SYNC_STAGES=2, LOCK_FILTER=64, MIN_PULSE=16: release reset_n with lock high from t0 -> reset_req stays 1 for 66 cycles, 0 from cycle 67 onward; cause=0001.
- Lock loss in RUN (cause pre-cleared): pll_locked_async low for 5 cycles, then high -> reset_req high 3 cycles after the drop; release no earlier than 16 cycles after the ASSERT entry edge and 64 cycles after lock_s returns high; cause=0010.
- Soft handshake: soft_req high, held -> reset_req high next cycle for 16 cycles; soft_ack rises the cycle after reset_req falls; soft_req low -> soft_ack low next cycle; no second reset; cause=0100.
- Watchdog with WDT_TIMEOUT=100: enable, no kicks -> reset_req high after 100 RUN cycles, cause=1000. Kicking every 50 cycles -> no reset for 10000 cycles.
- Simultaneous: soft_req and lock drop in the same RUN cycle, together with cause_clr -> single ASSERT; cause=0110; soft_ack after completion.
- Reset mid-operation: reset_n low during ASSERT with soft_ack pending -> reset_req=1, soft_ack=0, cause=0001 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reset_req_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rst_pkg : shared types and constants for the reset-request controller |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
package rst_pkg;

  typedef enum logic [0:0] {
    ASSERT = 1'b0,
    RUN    = 1'b1
  } state_e;

  localparam int CAUSE_W    = 4;
  localparam int CAUSE_POR  = 0;
  localparam int CAUSE_LOCK = 1;
  localparam int CAUSE_SOFT = 2;
  localparam int CAUSE_WDT  = 3;

  localparam logic [CAUSE_W-1:0] CAUSE_RESET = CAUSE_W'(1) << CAUSE_POR;

endpackage
`default_nettype wire

// File: rtl/reset_req_ctrl_bit_sync.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bit_sync : multi-flop single-bit synchroniser, async reset to 0       |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_req_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | reset_req_ctrl : merges PLL lock, soft reset and watchdog into one     |
// | minimum-width reset request with a sticky cause register. Rev 1.0     |
// +-----------------------------------------------------------------------+
module reset_req_ctrl
  import rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_FILTER = 64,
  parameter int unsigned MIN_PULSE   = 16,
  parameter logic [23:0] WDT_TIMEOUT = 24'd10000000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pll_locked_async,
  input  logic               soft_req,
  output logic               soft_ack,
  input  logic               wdt_enable,
  input  logic               wdt_kick,
  input  logic               cause_clr,
  output logic               reset_req,
  output logic [CAUSE_W-1:0] cause
);

  localparam int FILT_W  = $clog2(LOCK_FILTER + 1);
  localparam int PULSE_W = $clog2(MIN_PULSE + 1);
  localparam int WDT_W   = $clog2(32'(WDT_TIMEOUT) + 1);

  localparam logic [FILT_W-1:0]  FILT_MAX  = FILT_W'(LOCK_FILTER);
  localparam logic [PULSE_W-1:0] PULSE_MAX = PULSE_W'(MIN_PULSE);
  localparam logic [WDT_W-1:0]   WDT_LAST  = WDT_W'(WDT_TIMEOUT - 24'd1);

  state_e             state_q, state_d;
  logic [FILT_W-1:0]  filter_q, filter_d;
  logic [PULSE_W-1:0] pulse_q, pulse_d;
  logic [WDT_W-1:0]   wdt_q, wdt_d;
  logic               soft_pend_q, soft_pend_d;
  logic               soft_ack_q, soft_ack_d;
  logic               reset_req_q, reset_req_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [CAUSE_W-1:0] cause_set;

  logic lock_s;
  logic lock_ok;
  logic ev_lock, ev_wdt, ev_soft, ev_any;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (pll_locked_async),
    .q_o   (lock_s)
  );

  assign lock_ok = (filter_q == FILT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ASSERT;
      filter_q    <= '0;
      pulse_q     <= '0;
      wdt_q       <= '0;
      soft_pend_q <= 1'b0;
      soft_ack_q  <= 1'b0;
      reset_req_q <= 1'b1;
      cause_q     <= CAUSE_RESET;
    end else begin
      state_q     <= state_d;
      filter_q    <= filter_d;
      pulse_q     <= pulse_d;
      wdt_q       <= wdt_d;
      soft_pend_q <= soft_pend_d;
      soft_ack_q  <= soft_ack_d;
      reset_req_q <= reset_req_d;
      cause_q     <= cause_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pulse_d     = pulse_q;
    wdt_d       = '0;
    soft_pend_d = soft_pend_q;
    cause_set   = '0;
    ev_lock     = 1'b0;
    ev_wdt      = 1'b0;
    ev_soft     = 1'b0;

    if (!lock_s) begin
      filter_d = '0;
    end else if (lock_ok) begin
      filter_d = filter_q;
    end else begin
      filter_d = filter_q + FILT_W'(1);
    end

    // Exit events only count while running; all of them are sampled together.
    if (state_q == RUN) begin
      ev_lock = !lock_s;
      ev_wdt  = wdt_enable && (wdt_q == WDT_LAST) && !wdt_kick;
      ev_soft = soft_req && !soft_ack_q && !soft_pend_q;
    end
    ev_any = ev_lock || ev_wdt || ev_soft;

    if (state_q == ASSERT) begin
      if (pulse_q != PULSE_MAX) begin
        pulse_d = pulse_q + PULSE_W'(1);
      end
      if ((pulse_q == PULSE_MAX) && lock_ok) begin
        state_d = RUN;
      end
    end else if (ev_any) begin
      state_d = ASSERT;
      pulse_d = '0;
      if (ev_soft) begin
        soft_pend_d = 1'b1;
      end
    end else begin
      if (wdt_enable && !wdt_kick) begin
        wdt_d = wdt_q + WDT_W'(1);
      end
      soft_pend_d = 1'b0;
    end

    // Ack rises once a soft-triggered reset has fully completed, then tracks soft_req low.
    if (soft_ack_q) begin
      soft_ack_d = soft_req;
    end else begin
      soft_ack_d = (state_q == RUN) && soft_pend_q && !ev_any;
    end

    cause_set[CAUSE_LOCK] = ev_lock;
    cause_set[CAUSE_SOFT] = ev_soft;
    cause_set[CAUSE_WDT]  = ev_wdt;
    cause_d = (cause_clr ? '0 : cause_q) | cause_set;

    reset_req_d = (state_d == ASSERT);
  end

  assign reset_req = reset_req_q;
  assign soft_ack  = soft_ack_q;
  assign cause     = cause_q;

endmodule
`default_nettype wire
